// File: rtl/fabric_temporal_sw_buffered.sv
// Tag-matching temporal crossbar: per-output round-robin arbitration into a FIFO,
// with broadcast beats consumed once every routed output has taken one copy.
module fabric_temporal_sw_buffered #(
  parameter int NUM_INPUTS      = 2,
  parameter int NUM_OUTPUTS     = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int TAG_WIDTH       = 4,
  parameter int NUM_ROUTE_TABLE = 4,
  parameter logic [NUM_OUTPUTS*NUM_INPUTS-1:0] CONNECTIVITY = '1,
  parameter int FIFO_DEPTH      = 2,
  localparam int PAYLOAD_WIDTH  = DATA_WIDTH + TAG_WIDTH,
  localparam int NUM_CONNECTED  = $countones(CONNECTIVITY),
  localparam int ENTRY_WIDTH    = 1 + TAG_WIDTH + NUM_CONNECTED,
  localparam int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_INPUTS-1:0]                  in_valid,
  output logic [NUM_INPUTS-1:0]                  in_ready,
  input  logic [NUM_INPUTS*PAYLOAD_WIDTH-1:0]    in_data,
  output logic [NUM_OUTPUTS-1:0]                 out_valid,
  input  logic [NUM_OUTPUTS-1:0]                 out_ready,
  output logic [NUM_OUTPUTS*PAYLOAD_WIDTH-1:0]   out_data,
  output logic [NUM_OUTPUTS*CNT_W-1:0]           out_occupancy,
  input  logic [NUM_ROUTE_TABLE*ENTRY_WIDTH-1:0] cfg_data,
  output logic                                   error_valid,
  output logic [15:0]                            error_code
);

  localparam int NE    = NUM_OUTPUTS * NUM_INPUTS;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RR_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  localparam logic [15:0] ERR_ROUTE_CONFLICT = 16'd1;
  localparam logic [15:0] ERR_DUP_TAG        = 16'd2;
  localparam logic [15:0] ERR_NO_MATCH       = 16'd3;
  localparam logic [15:0] ERR_UNROUTED       = 16'd4;

  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $fatal(1, "FIFO_DEPTH must be at least 1");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RR_W-1:0] rr_inc(input logic [RR_W-1:0] p);
    return (int'(p) == NUM_INPUTS - 1) ? '0 : p + 1'b1;
  endfunction

  logic                       ent_vld  [NUM_ROUTE_TABLE];
  logic [TAG_WIDTH-1:0]       ent_tag  [NUM_ROUTE_TABLE];
  logic [NE-1:0]              ent_exp  [NUM_ROUTE_TABLE];
  logic [NUM_INPUTS-1:0]      match;
  logic [NUM_OUTPUTS-1:0]     r_vec    [NUM_INPUTS];
  logic [NUM_OUTPUTS-1:0]     served   [NUM_INPUTS];
  logic [NUM_OUTPUTS-1:0]     gcol     [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]      grant    [NUM_OUTPUTS];
  logic [RR_W-1:0]            win_idx  [NUM_OUTPUTS];
  logic [RR_W-1:0]            rr_ptr   [NUM_OUTPUTS];
  logic [PAYLOAD_WIDTH-1:0]   push_data[NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0]     push, pop, full;
  logic [PTR_W-1:0]           wr_ptr   [NUM_OUTPUTS];
  logic [PTR_W-1:0]           rd_ptr   [NUM_OUTPUTS];
  logic [CNT_W-1:0]           cnt      [NUM_OUTPUTS];
  logic [PAYLOAD_WIDTH-1:0]   mem      [NUM_OUTPUTS][FIFO_DEPTH];
  logic                       err_any;
  logic [15:0]                err_code_d;

  // Route-table decode: compressed route bits expand onto the connected edges.
  always_comb begin
    int k;
    for (int e = 0; e < NUM_ROUTE_TABLE; e++) begin
      ent_vld[e] = cfg_data[e*ENTRY_WIDTH];
      ent_tag[e] = cfg_data[e*ENTRY_WIDTH+1 +: TAG_WIDTH];
      ent_exp[e] = '0;
      k = 0;
      for (int b = 0; b < NE; b++) begin
        if (CONNECTIVITY[b]) begin
          ent_exp[e][b] = cfg_data[e*ENTRY_WIDTH+1+TAG_WIDTH+k];
          k++;
        end
      end
    end
  end

  // Tag match; ascending scan lets the highest matching entry win.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      match[i] = 1'b0;
      r_vec[i] = '0;
      for (int e = 0; e < NUM_ROUTE_TABLE; e++) begin
        if (ent_vld[e] && ent_tag[e] == in_data[i*PAYLOAD_WIDTH+DATA_WIDTH +: TAG_WIDTH]) begin
          match[i] = 1'b1;
          for (int o = 0; o < NUM_OUTPUTS; o++) r_vec[i][o] = ent_exp[e][o*NUM_INPUTS+i];
        end
      end
    end
  end

  // Arbitration: eligibility uses registered FIFO fullness only, so out_ready never reaches in_ready.
  always_comb begin
    int  idx;
    logic found;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      full[o]      = (cnt[o] == CNT_W'(FIFO_DEPTH));
      grant[o]     = '0;
      win_idx[o]   = '0;
      push_data[o] = '0;
      found        = 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
        idx = (int'(rr_ptr[o]) + k) % NUM_INPUTS;
        if (!found && !full[o] && in_valid[idx] && match[idx] && r_vec[idx][o] && !served[idx][o]) begin
          found          = 1'b1;
          grant[o][idx]  = 1'b1;
          win_idx[o]     = RR_W'(idx);
          push_data[o]   = in_data[idx*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        end
      end
      push[o] = found;
    end
  end

  always_comb begin
    logic done;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      done = 1'b1;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        gcol[i][o] = grant[o][i];
        if (r_vec[i][o] && !(served[i][o] || grant[o][i])) done = 1'b0;
      end
      in_ready[i] = in_valid[i] & match[i] & (|r_vec[i]) & done;
    end
  end

  // Error detection; lowest code wins when several fire together.
  always_comb begin
    int   n;
    logic e_conf, e_dup, e_nom, e_unr;
    e_conf = 1'b0; e_dup = 1'b0; e_nom = 1'b0; e_unr = 1'b0;
    for (int e = 0; e < NUM_ROUTE_TABLE; e++) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        n = 0;
        for (int i = 0; i < NUM_INPUTS; i++) n += int'(ent_exp[e][o*NUM_INPUTS+i]);
        if (ent_vld[e] && n > 1) e_conf = 1'b1;
      end
      for (int f = e + 1; f < NUM_ROUTE_TABLE; f++)
        if (ent_vld[e] && ent_vld[f] && ent_tag[e] == ent_tag[f]) e_dup = 1'b1;
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (in_valid[i] && !match[i]) e_nom = 1'b1;
      if (in_valid[i] && match[i] && r_vec[i] == '0) e_unr = 1'b1;
    end
    err_any    = e_conf | e_dup | e_nom | e_unr;
    err_code_d = e_conf ? ERR_ROUTE_CONFLICT :
                 e_dup  ? ERR_DUP_TAG :
                 e_nom  ? ERR_NO_MATCH :
                 e_unr  ? ERR_UNROUTED : 16'd0;
  end

  always_comb begin
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      out_valid[o] = (cnt[o] != '0);
      pop[o]       = out_valid[o] & out_ready[o];
      out_data[o*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = out_valid[o] ? mem[o][rd_ptr[o]] : '0;
      out_occupancy[o*CNT_W +: CNT_W] = cnt[o];
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INPUTS; i++) served[i] <= '0;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        rr_ptr[o] <= '0;
        wr_ptr[o] <= '0;
        rd_ptr[o] <= '0;
        cnt[o]    <= '0;
      end
      error_valid <= 1'b0;
      error_code  <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++)
        served[i] <= in_ready[i] ? '0 : (served[i] | gcol[i]);
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        if (push[o]) begin
          rr_ptr[o] <= rr_inc(win_idx[o]);
          wr_ptr[o] <= ptr_inc(wr_ptr[o]);
        end
        if (pop[o]) rd_ptr[o] <= ptr_inc(rd_ptr[o]);
        cnt[o] <= cnt[o] + CNT_W'(push[o]) - CNT_W'(pop[o]);
      end
      if (!error_valid && err_any) begin
        error_valid <= 1'b1;
        error_code  <= err_code_d;
      end
    end
  end

  // FIFO storage (data path, not reset).
  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_OUTPUTS; o++)
      if (push[o]) mem[o][wr_ptr[o]] <= push_data[o];
  end

endmodule

// File: tb/tb_fabric_temporal_sw_buffered.sv
// Directed bench for the 2x2 buffered temporal switch (default parameters).
module tb_fabric_temporal_sw_buffered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [71:0] in_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [71:0] out_data;
  logic [3:0]  out_occupancy;
  logic [35:0] cfg_data;
  logic        error_valid;
  logic [15:0] error_code;

  int checks = 0;
  int errors = 0;

  fabric_temporal_sw_buffered dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_occupancy(out_occupancy), .cfg_data(cfg_data),
    .error_valid(error_valid), .error_code(error_code)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ent(input logic [3:0] tag, input logic [3:0] rt);
    return {rt, tag, 1'b1};
  endfunction

  function automatic logic [35:0] pay(input logic [3:0] tag, input logic [31:0] d);
    return {tag, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = '0; cfg_data = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_occ", 64'(out_occupancy), 64'h0);
    chk("rst_out_data", 64'(out_data[35:0]), 64'h0);
    chk("rst_err_valid", 64'(error_valid), 64'h0);
    chk("rst_err_code", 64'(error_code), 64'h0);

    // Unicast in0 -> out1
    cfg_data = {27'd0, ent(4'd3, 4'b0100)};
    in_valid = 2'b01; in_data = {36'd0, pay(4'd3, 32'hDEADBEEF)};
    #1 chk("uni_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = '0;
    #1 chk("uni_out_valid", 64'(out_valid), 64'h2);
    chk("uni_out_data", 64'(out_data[71:36]), 64'(pay(4'd3, 32'hDEADBEEF)));
    chk("uni_err_none", 64'(error_valid), 64'h0);

    // Staggered broadcast: out1 pre-filled, out0 gets its copy first
    do_reset();
    cfg_data = {18'd0, ent(4'd6, 4'b1000), ent(4'd5, 4'b0101)};
    in_valid = 2'b10; in_data = {pay(4'd6, 32'hA), 36'd0};
    #1 chk("pf_a_ready", 64'(in_ready), 64'h2);
    tick();
    in_data = {pay(4'd6, 32'hB), 36'd0};
    #1 chk("pf_b_ready", 64'(in_ready), 64'h2);
    tick();
    in_valid = 2'b01; in_data = {36'd0, pay(4'd5, 32'hC)};
    #1 chk("bc_occ_pre", 64'(out_occupancy), 64'h8);
    chk("bc_c0_ready", 64'(in_ready), 64'h0);
    tick();
    chk("bc_occ_c1", 64'(out_occupancy), 64'h9);
    chk("bc_c1_ready", 64'(in_ready), 64'h0);
    out_ready = 2'b10;
    #1 chk("bc_no_comb_path", 64'(in_ready), 64'h0);
    tick();
    out_ready = 2'b00;
    #1 chk("bc_done_ready", 64'(in_ready), 64'h1);
    chk("bc_occ_popped", 64'(out_occupancy), 64'h5);
    tick();
    in_valid = '0;
    #1 chk("bc_occ_final", 64'(out_occupancy), 64'h9);
    chk("bc_out0_data", 64'(out_data[35:0]), 64'(pay(4'd5, 32'hC)));
    chk("bc_out1_head", 64'(out_data[71:36]), 64'(pay(4'd6, 32'hB)));
    out_ready = 2'b11;
    tick();
    chk("bc_drain_valid", 64'(out_valid), 64'h2);
    chk("bc_out1_copy", 64'(out_data[71:36]), 64'(pay(4'd5, 32'hC)));
    tick();
    chk("bc_drain_empty", 64'(out_valid), 64'h0);

    // Round-robin contention on out0
    do_reset();
    cfg_data = {18'd0, ent(4'd2, 4'b0010), ent(4'd1, 4'b0001)};
    in_valid = 2'b11; in_data = {pay(4'd2, 32'h1111), pay(4'd1, 32'h0000)};
    out_ready = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("rr_ready%0d", c), 64'(in_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      if (c > 0)
        chk($sformatf("rr_data%0d", c), 64'(out_data[35:0]),
            ((c - 1) % 2 == 0) ? 64'(pay(4'd1, 32'h0000)) : 64'(pay(4'd2, 32'h1111)));
      tick();
    end

    // Backpressure on out0
    do_reset();
    cfg_data = {27'd0, ent(4'd4, 4'b0001)};
    for (int b = 1; b <= 3; b++) begin
      in_valid = 2'b01; in_data = {36'd0, pay(4'd4, 32'(b))};
      #1 chk($sformatf("bp_ready%0d", b), 64'(in_ready), (b < 3) ? 64'h1 : 64'h0);
      if (b < 3) tick();
    end
    chk("bp_occ_full", 64'(out_occupancy[1:0]), 64'h2);
    out_ready = 2'b01;
    #1 chk("bp_full_ready", 64'(in_ready), 64'h0);
    chk("bp_head1", 64'(out_data[35:0]), 64'(pay(4'd4, 32'd1)));
    tick();
    chk("bp_ready3", 64'(in_ready), 64'h1);
    chk("bp_head2", 64'(out_data[35:0]), 64'(pay(4'd4, 32'd2)));
    tick();
    in_valid = '0;
    #1 chk("bp_head3", 64'(out_data[35:0]), 64'(pay(4'd4, 32'd3)));
    tick();
    chk("bp_empty", 64'(out_valid), 64'h0);

    // Errors: duplicate tag plus unmatched input
    do_reset();
    cfg_data = {18'd0, ent(4'd7, 4'b1000), ent(4'd7, 4'b0001)};
    in_valid = 2'b01; in_data = {36'd0, pay(4'd9, 32'h5)};
    #1 chk("err_not_yet", 64'(error_valid), 64'h0);
    chk("err_stall", 64'(in_ready), 64'h0);
    tick();
    chk("err_valid", 64'(error_valid), 64'h1);
    chk("err_code_dup", 64'(error_code), 64'h2);
    cfg_data = '0; in_valid = '0;
    tick();
    chk("err_hold_valid", 64'(error_valid), 64'h1);
    chk("err_hold_code", 64'(error_code), 64'h2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("err_rst_valid", 64'(error_valid), 64'h0);
    chk("err_rst_code", 64'(error_code), 64'h0);
    cfg_data = {27'd0, ent(4'd8, 4'b0011)};
    in_valid = 2'b01; in_data = {36'd0, pay(4'd9, 32'h5)};
    tick();
    chk("err_code_conflict", 64'(error_code), 64'h1);

    // Reset in the middle of a broadcast
    do_reset();
    cfg_data = {18'd0, ent(4'd6, 4'b1000), ent(4'd5, 4'b0101)};
    in_valid = 2'b10; in_data = {pay(4'd6, 32'hA), 36'd0};
    tick();
    in_data = {pay(4'd6, 32'hB), 36'd0};
    tick();
    in_valid = 2'b01; in_data = {36'd0, pay(4'd5, 32'hC)};
    tick();
    chk("mr_partial_occ", 64'(out_occupancy), 64'h9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_occ_clear", 64'(out_occupancy), 64'h0);
    chk("mr_valid_clear", 64'(out_valid), 64'h0);
    chk("mr_data_clear", 64'(out_data), 64'h0);
    chk("mr_replay_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = '0;
    #1 chk("mr_occ_once", 64'(out_occupancy), 64'h5);
    chk("mr_out0", 64'(out_data[35:0]), 64'(pay(4'd5, 32'hC)));
    chk("mr_out1", 64'(out_data[71:36]), 64'(pay(4'd5, 32'hC)));
    tick();
    chk("mr_no_dup", 64'(out_occupancy), 64'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fabric_temporal_sw_buffered.md
Name: fabric_temporal_sw_buffered

Overview:
Tag-matching temporal crossbar with a per-output FIFO and non-atomic broadcast. Each input's tag selects a route-table entry. Each output arbitrates round-robin among eligible inputs and pushes the winner into its FIFO. A broadcast input is consumed only once every target has received exactly one copy, but the copies may be delivered in different cycles. It is the next-generation temporal switch for the fabric: out_ready has no combinational path to in_ready, and it adds buffering depth.

Parameters:
NUM_INPUTS, 2, input port count (>=1)
NUM_OUTPUTS, 2, output port count (>=1)
DATA_WIDTH, 32, data bits per beat
TAG_WIDTH, 4, tag bits (>=1), placed above data in each payload
NUM_ROUTE_TABLE, 4, route-table entries (>=1)
CONNECTIVITY, all ones, [NUM_OUTPUTS*NUM_INPUTS] mask; bit o*NUM_INPUTS+i set means edge input i -> output o exists
FIFO_DEPTH, 2, entries per output FIFO (>=1); violation causes elaboration $fatal
(localparams) PAYLOAD_WIDTH = DATA_WIDTH+TAG_WIDTH; NUM_CONNECTED = popcount(CONNECTIVITY); ENTRY_WIDTH = 1+TAG_WIDTH+NUM_CONNECTED; CNT_W = $clog2(FIFO_DEPTH+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous active-low
in_valid  in  NUM_INPUTS  per-input valid
in_ready  out  NUM_INPUTS  per-input ready (beat consumed)
in_data  in  NUM_INPUTS*PAYLOAD_WIDTH  packed payloads; port i at [i*PW +: PW]; {tag, data}
out_valid  out  NUM_OUTPUTS  FIFO non-empty
out_ready  in  NUM_OUTPUTS  downstream ready
out_data  out  NUM_OUTPUTS*PAYLOAD_WIDTH  FIFO head payload, tag unchanged
out_occupancy  out  NUM_OUTPUTS*CNT_W  per-output FIFO entry count
cfg_data  in  NUM_ROUTE_TABLE*ENTRY_WIDTH  entry e at [e*ENTRY_WIDTH +:]; fields LSB->MSB: valid(1), tag, routes(NUM_CONNECTED)
error_valid  out  1  sticky error flag
error_code  out  16  first-captured error code

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low. While rst_n=0 at a clk edge:
  - all FIFOs empty, so out_valid=0, out_data=0, out_occupancy=0;
  - rr_ptr[o]=0 and served[i]=0;
  - error_valid=0, error_code=0.
- Reset mid-broadcast discards the partial delivery. The next beat starts with a fresh served mask.
- Route expansion: compressed bit k maps to the k-th set CONNECTIVITY bit, scanned output-major (o=0..), input-minor (i=0..). Unconnected edges are 0.
- Tag match: input i matches entry e when valid[e] is set and tag[e] equals the input tag. With duplicate tags, the highest e wins. The match gives the route vector R[i][o].
- Pending targets: P[i][o] = in_valid[i] & match[i] & R[i][o] & ~served[i][o].
- Eligibility: output o considers input i when P[i][o] is set and FIFO o is not full. There is no empty-bypass, so out_ready does not affect the decision in the same cycle.
- Arbitration: per output, scan i = (rr_ptr[o]+k) mod NUM_INPUTS for k=0..NUM_INPUTS-1; the first eligible input wins.
- Push: on a win, FIFO o stores in_data[i] at the clock edge, and rr_ptr[o] becomes (winner+1) mod NUM_INPUTS.
- Consume: in_ready[i] = in_valid & match & routed & (every routed o is either already served or granted this cycle).
  - On consume, served[i] clears to 0.
  - Otherwise served[i] |= grants this cycle.
- in_ready is combinational from in_valid, in_data and cfg_data plus registered state only.
- Sources must hold their payload stable until in_ready. served is cleared only by consume or reset.
- Unmatched or unrouted inputs never assert in_ready; they stall and raise an error.
- FIFO:
  - latency 1 cycle from push to out_valid;
  - pop when out_valid & out_ready;
  - simultaneous push and pop on a full FIFO is not allowed (full blocks the push that cycle), so occupancy stays within 0..FIFO_DEPTH;
  - simultaneous push and pop on a non-full FIFO leaves occupancy unchanged;
  - read and write pointers wrap modulo FIFO_DEPTH, including non-power-of-2 depths.
- Errors (combinational detect, latched):
  - CFG_TEMPORAL_SW_ROUTE_SAME_TAG_INPUTS_TO_SAME_OUTPUT: a valid entry routes more than one input to one output;
  - CFG_TEMPORAL_SW_DUP_TAG: two valid entries share a tag;
  - RT_TEMPORAL_SW_NO_MATCH: an input is valid with no matching entry;
  - RT_TEMPORAL_SW_UNROUTED_INPUT: an input is valid and matched but has a zero route vector.
- Error priority and latching:
  - when several errors are detected together, the numerically lowest code wins;
  - the first detection sets error_valid at the next edge, and the code holds until reset;
  - switching continues after an error.

Test Plan:
- 2x2 unicast, DATA_WIDTH=32, TAG_WIDTH=4, FIFO_DEPTH=2. Entry0={valid, tag 3, in0->out1}; drive in0 with tag 3, data 0xDEADBEEF.
  -> in_ready[0]=1 in cycle 0.
  -> out_valid[1]=1 with that payload in cycle 1; out_valid[0] stays 0.
- Staggered broadcast. Entry0 tag 5 routes in0->out0 and in0->out1. Pre-fill out1 to occupancy 2 with out_ready=0.
  -> cycle 0: push to out0, in_ready[0]=0.
  -> raise out_ready[1] for one pop: the push to out1 happens, in_ready[0]=1 that cycle.
  -> out0 holds exactly one copy.
- RR contention. Tag 1 routes in0->out0, tag 2 routes in1->out0; both inputs valid continuously, out_ready=1.
  -> out0 sequence is in0, in1, in0, in1; the first grant after reset goes to in0.
- Backpressure. out_ready[0]=0; send 3 beats to out0.
  -> beats 1-2 accepted, out_occupancy[0]=2, beat 3 sees in_ready=0.
  -> after out_ready=1, beats drain in order 1, 2, 3.
- Errors. Two valid entries with tag 7, plus in0 valid with tag 9 unmatched.
  -> error_valid=1 one cycle later, error_code = min(DUP_TAG, NO_MATCH).
  -> the code holds after the condition clears; rst_n=0 for one edge clears it.
- Reset mid-broadcast. Hold rst_n=0 for one edge after a partial broadcast.
  -> FIFOs empty, served cleared.
  -> the replayed beat is delivered once to each target.
